// File: rtl/osc_cmd_pkg.sv
// Shared command-path definitions: FSM encodings, command size and field
// positions used by both the assembler and the configuration stage.
package osc_cmd_pkg;

  localparam int CMD_BYTES = 3;
  localparam int CMD_W     = 8 * CMD_BYTES;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    FULL    = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // Command field positions within {byte0, byte1, byte2}
  localparam int OPC_MSB  = 23;
  localparam int OPC_LSB  = 16;
  localparam int GAIN_MSB = 12;
  localparam int GAIN_LSB = 10;
  localparam int CHAN_MSB = 9;
  localparam int CHAN_LSB = 8;
  localparam int ARG_MSB  = 7;
  localparam int ARG_LSB  = 0;

  function automatic logic [7:0] cmd_opcode(input logic [CMD_W-1:0] c);
    return c[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cmd_byte_timer.sv
// Inter-byte idle counter; expired is high on the last allowed idle cycle.
module cmd_byte_timer #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cmd_assembler.sv
// Assembles three UART bytes into a 24-bit command with backpressure and an
// inter-byte timeout; forwards single-byte responses to the UART transmitter.
module cmd_assembler
  import osc_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             rx_clr_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic [7:0]       resp_data,
  input  logic             send_resp,
  output logic             resp_sent,
  output logic [7:0]       tx_data,
  output logic             trmt,
  input  logic             tx_done
);

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic [CMD_BYTES-2:0][7:0] slot;  // slot[0] = byte0, slot[1] = byte1
  logic accepting, tmr_clr, tmr_en, expired;

  assign accepting  = (rx_state != FULL);
  assign rx_clr_rdy = rx_rdy & accepting;
  assign tmr_en     = (rx_state == WAIT_B1) || (rx_state == WAIT_B2);
  assign tmr_clr    = rx_clr_rdy | ~tmr_en;

  cmd_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // A byte arriving on the expiry cycle takes priority over the discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= WAIT_B0;
      slot     <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      case (rx_state)
        WAIT_B0:
          if (rx_rdy) begin
            slot[0]  <= rx_data;
            rx_state <= WAIT_B1;
          end
        WAIT_B1:
          if (rx_rdy) begin
            slot[1]  <= rx_data;
            rx_state <= WAIT_B2;
          end else if (expired) begin
            slot     <= '0;
            rx_state <= WAIT_B0;
          end
        WAIT_B2:
          if (rx_rdy) begin
            cmd      <= {slot[0], slot[1], rx_data};
            cmd_rdy  <= 1'b1;
            rx_state <= FULL;
          end else if (expired) begin
            slot     <= '0;
            rx_state <= WAIT_B0;
          end
        FULL:
          if (clr_cmd_rdy) begin
            cmd_rdy  <= 1'b0;
            rx_state <= WAIT_B0;
          end
        default: rx_state <= WAIT_B0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE:
          if (send_resp) begin
            tx_data  <= resp_data;
            trmt     <= 1'b1;
            tx_state <= TX_BUSY;
          end
        TX_BUSY:
          if (tx_done) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed and randomized bench for cmd_assembler against a queue-based
// reference model of command assembly, timeout and response forwarding.
module tb_cmd_assembler;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_clr_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  cmd_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .rx_clr_rdy  (rx_clr_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, idle age since last accepted byte
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_full;
  logic [23:0] m_cmd;
  bit          m_rdy;
  bit          m_busy;
  logic [7:0]  m_tx;
  bit          m_trmt;
  bit          m_sent;

  task automatic m_reset();
    m_q.delete();
    m_idle = 0;
    m_full = 0;
    m_cmd  = '0;
    m_rdy  = 0;
    m_busy = 0;
    m_tx   = '0;
    m_trmt = 0;
    m_sent = 0;
  endtask

  // Advance model by one cycle using current inputs, then clock the DUT.
  task automatic step();
    bit acc;
    if (rst) begin
      m_reset();
    end else begin
      acc = rx_rdy && !m_full;
      if (acc) begin
        m_q.push_back(rx_data);
        m_idle = 0;
        if (m_q.size() == 3) begin
          m_cmd = {m_q[0], m_q[1], m_q[2]};
          m_rdy = 1;
          m_full = 1;
          m_q.delete();
        end
      end else if (m_full) begin
        if (clr_cmd_rdy) begin
          m_full = 0;
          m_rdy  = 0;
        end
      end else if (m_q.size() != 0) begin
        m_idle++;
        if (m_idle == T) m_q.delete();
      end
      m_trmt = 0;
      m_sent = 0;
      if (!m_busy) begin
        if (send_resp) begin
          m_tx = resp_data;
          m_trmt = 1;
          m_busy = 1;
        end
      end else if (tx_done) begin
        m_sent = 1;
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data = '0; rx_rdy = 0; clr_cmd_rdy = 0;
    resp_data = '0; send_resp = 0; tx_done = 0;
    step();
    step();
    checks++;
    if ({cmd, cmd_rdy, tx_data, trmt, resp_sent} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {cmd, cmd_rdy, tx_data, trmt, resp_sent});
    end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_basic_cmd();
    logic [7:0] bytes [3];
    bytes[0] = 8'h02; bytes[1] = 8'h05; bytes[2] = 8'h14;
    for (int i = 0; i < 3; i++) begin
      rx_data = bytes[i];
      rx_rdy  = 1'b1;
      #1;
      checks++;
      if (rx_clr_rdy !== 1'b1) begin
        errors++;
        $display("FAIL basic_clr_rdy[%0d]: got %b want 1", i, rx_clr_rdy);
      end
      step();
      rx_rdy = 1'b0;
      if (i == 2) begin
        checks++;
        if ({cmd, cmd_rdy} !== {24'h020514, 1'b1}) begin
          errors++;
          $display("FAIL basic_cmd: got %h/%b want 020514/1", cmd, cmd_rdy);
        end
      end else begin
        checks++;
        if (cmd_rdy !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_rdy[%0d]: got %b want 0", i, cmd_rdy);
        end
      end
      #1;
      checks++;
      if (rx_clr_rdy !== 1'b0) begin
        errors++;
        $display("FAIL basic_clr_idle[%0d]: got %b want 0", i, rx_clr_rdy);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rx_clr_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b want 0", i, rx_clr_rdy);
      end
      step();
    end
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (rx_clr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_clr_cycle: got %b want 0", rx_clr_rdy);
    end
    step();
    clr_cmd_rdy = 1'b0;
    checks++;
    if ({cmd, cmd_rdy} !== {24'h020514, 1'b0}) begin
      errors++;
      $display("FAIL bp_after_clr: got %h/%b want 020514/0", cmd, cmd_rdy);
    end
    #1;
    checks++;
    if (rx_clr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got %b want 1", rx_clr_rdy);
    end
    step();
    rx_rdy = 1'b0;
    send_byte(8'h88);
    send_byte(8'h99);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h778899, 1'b1}) begin
      errors++;
      $display("FAIL bp_next_cmd: got %h/%b want 778899/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_timeout();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    send_byte(8'h08);
    send_byte(8'h3F);
    repeat (T) step();
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'h00);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h090100, 1'b1}) begin
      errors++;
      $display("FAIL timeout_discard: got %h/%b want 090100/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_timeout_edge();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    send_byte(8'h11);
    repeat (T - 1) step();
    send_byte(8'h22);
    repeat (T - 1) step();
    send_byte(8'h33);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h112233, 1'b1}) begin
      errors++;
      $display("FAIL timeout_edge: got %h/%b want 112233/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++;
    if (resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL tx_done_idle: got %b want 0", resp_sent);
    end
    resp_data = 8'hA5;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    checks++;
    if ({tx_data, trmt} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL tx_start: got %h/%b want a5/1", tx_data, trmt);
    end
    resp_data = 8'h3C;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    checks++;
    if ({tx_data, trmt} !== {8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL tx_busy_drop: got %h/%b want a5/0", tx_data, trmt);
    end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++;
    if ({resp_sent, trmt} !== 2'b10) begin
      errors++;
      $display("FAIL tx_sent: got %b want 10", {resp_sent, trmt});
    end
    step();
    checks++;
    if (resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL tx_sent_pulse: got %b want 0", resp_sent);
    end
  endtask

  task automatic test_reset_mid();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    send_byte(8'hDE);
    send_byte(8'hAD);
    resp_data = 8'h5A;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    checks++;
    if (trmt !== 1'b1) begin
      errors++;
      $display("FAIL mid_trmt: got %b want 1", trmt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd, cmd_rdy, tx_data, trmt, resp_sent} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0", {cmd, cmd_rdy, tx_data, trmt, resp_sent});
    end
    step();
    rst = 1'b0;
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h01);
    checks++;
    if ({cmd, cmd_rdy} !== {24'hBEEF01, 1'b1}) begin
      errors++;
      $display("FAIL mid_reassemble: got %h/%b want beef01/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_random();
    bit pend = 0;
    bit exp_acc;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 11) == 0) begin
        pend = 1;
        rx_data = 8'($urandom);
      end
      rx_rdy      = pend;
      clr_cmd_rdy = ($urandom_range(0, 3) == 0);
      send_resp   = ($urandom_range(0, 4) == 0);
      resp_data   = 8'($urandom);
      tx_done     = ($urandom_range(0, 5) == 0);
      #1;
      exp_acc = pend && !m_full;
      checks++;
      if (rx_clr_rdy !== exp_acc) begin
        errors++;
        $display("FAIL rand_clr_rdy[%0d]: got %b want %b", i, rx_clr_rdy, exp_acc);
      end
      step();
      if (exp_acc) pend = 0;
      checks++;
      if ({cmd, cmd_rdy, tx_data, trmt, resp_sent} !== {m_cmd, m_rdy, m_tx, m_trmt, m_sent}) begin
        errors++;
        $display("FAIL rand_outputs[%0d]: got %h want %h", i,
                 {cmd, cmd_rdy, tx_data, trmt, resp_sent}, {m_cmd, m_rdy, m_tx, m_trmt, m_sent});
      end
    end
    rx_rdy = 0; clr_cmd_rdy = 0; send_resp = 0; tx_done = 0;
  endtask

  initial begin
    test_reset();
    test_basic_cmd();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_tx();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
